// File: rtl/universal_shift_reg_if.sv
// universal_shift_reg_if: control/data bundle for universal_shift_reg.
// The master drives mode/enable/data/serial inputs and observes the register
// outputs; the slave (the register itself) does the reverse.
// Optional rot signal exists only when UNIVERSAL_SHIFT_REG_ROTATE_EN is defined.
interface universal_shift_reg_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH + 1);

   logic             en;
   logic [1:0]       mode;
   logic [WIDTH-1:0] d;
   logic             sin_r;
   logic             sin_l;
`ifdef UNIVERSAL_SHIFT_REG_ROTATE_EN
   logic             rot;
`endif
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] nq;
   logic             sout_r;
   logic             sout_l;
   logic [CW-1:0]    shift_cnt;
   logic             drained;

   modport master (
`ifdef UNIVERSAL_SHIFT_REG_ROTATE_EN
      output rot,
`endif
      output en, mode, d, sin_r, sin_l,
      input  q, nq, sout_r, sout_l, shift_cnt, drained
   );

   modport slave (
`ifdef UNIVERSAL_SHIFT_REG_ROTATE_EN
      input  rot,
`endif
      input  en, mode, d, sin_r, sin_l,
      output q, nq, sout_r, sout_l, shift_cnt, drained
   );
endinterface

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: WIDTH-bit hold / shift-right / shift-left / load
// register with complemented output, serial taps and a saturating count of
// shifts since the last load (drained flags the count reaching WIDTH).
// Optional feature macro: UNIVERSAL_SHIFT_REG_ROTATE_EN adds rot, which makes
// shifts recirculate the outgoing bit instead of taking the serial input.
module universal_shift_reg #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   universal_shift_reg_if.slave bus
);
   localparam int              CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   FULL = CW'(WIDTH);

   logic [WIDTH-1:0] r_q;
   logic [CW-1:0]    r_cnt;
   logic             r_drained;

   logic [WIDTH-1:0] w_q_nxt;
   logic [CW-1:0]    w_cnt_nxt;
   logic             w_shift;
   logic             w_load;
   logic             w_fill_r;
   logic             w_fill_l;

   // Next-state: pick the incoming bits, then apply this cycle's mode.
   always_comb begin
      w_fill_r = bus.sin_r;
      w_fill_l = bus.sin_l;
`ifdef UNIVERSAL_SHIFT_REG_ROTATE_EN
      if (bus.rot) begin
         w_fill_r = r_q[0];
         w_fill_l = r_q[WIDTH-1];
      end
`endif
      w_q_nxt = r_q;
      w_shift = 1'b0;
      w_load  = 1'b0;
      if (bus.en) begin
         case (bus.mode)
            2'b01: begin
               w_q_nxt = {w_fill_r, r_q[WIDTH-1:1]};
               w_shift = 1'b1;
            end
            2'b10: begin
               w_q_nxt = {r_q[WIDTH-2:0], w_fill_l};
               w_shift = 1'b1;
            end
            2'b11: begin
               w_q_nxt = bus.d;
               w_load  = 1'b1;
            end
            default: ;
         endcase
      end
      // Counter saturates at WIDTH; only a load (or reset) brings it back.
      w_cnt_nxt = r_cnt;
      if (w_load)
         w_cnt_nxt = '0;
      else if (w_shift && (r_cnt != FULL))
         w_cnt_nxt = r_cnt + 1'b1;
   end

   // State registers; drained is registered from the next count so it is
   // always coincident with shift_cnt == WIDTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q       <= RESET_VAL;
         r_cnt     <= '0;
         r_drained <= 1'b0;
      end else begin
         r_q       <= w_q_nxt;
         r_cnt     <= w_cnt_nxt;
         r_drained <= (w_cnt_nxt == FULL);
      end
   end

   // nq is derived from q so the two can never disagree.
   assign bus.q         = r_q;
   assign bus.nq        = ~r_q;
   assign bus.sout_r    = r_q[0];
   assign bus.sout_l    = r_q[WIDTH-1];
   assign bus.shift_cnt = r_cnt;
   assign bus.drained   = r_drained;
endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg (WIDTH=8, RESET_VAL=8'hA5).
// Stimulus pushes hand-computed expectations; monitors pop and compare one
// entry per clock edge (or on an asynchronous-reset check event).
module tb_universal_shift_reg;
   logic clk;
   logic rst_n;

   universal_shift_reg_if #(.WIDTH(8)) bus ();

   universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0] q;
      logic [3:0] cnt;
      logic       dr;
      string      nm;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   event ev_rst;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input exp_t e);
      tests++;
      if (bus.q !== e.q || bus.nq !== ~e.q || bus.sout_r !== e.q[0] ||
          bus.sout_l !== e.q[7] || bus.shift_cnt !== e.cnt || bus.drained !== e.dr) begin
         fails++;
         $display("FAIL %s: got q=%h nq=%h sout_r=%b sout_l=%b cnt=%0d drained=%b, want q=%h nq=%h cnt=%0d drained=%b",
                  e.nm, bus.q, bus.nq, bus.sout_r, bus.sout_l, bus.shift_cnt, bus.drained,
                  e.q, ~e.q, e.cnt, e.dr);
      end
   endtask

   task automatic push(input logic [7:0] eq, input logic [3:0] ec, input logic ed, input string nm);
      exp_t e;
      e.q = eq; e.cnt = ec; e.dr = ed; e.nm = nm;
      sb.push_back(e);
   endtask

   // One clocked operation: drive at negedge, expectation due after next posedge.
   task automatic cyc(input logic e, input logic [1:0] m, input logic [7:0] dv,
                      input logic sr, input logic sl,
                      input logic [7:0] eq, input logic [3:0] ec, input logic ed,
                      input string nm);
      @(negedge clk);
      bus.en = e; bus.mode = m; bus.d = dv; bus.sin_r = sr; bus.sin_l = sl;
      push(eq, ec, ed, nm);
   endtask

   // Edge monitor
   initial forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) chk(sb.pop_front());
   end

   // Asynchronous-reset monitor
   initial forever begin
      @(ev_rst);
      if (sb.size() > 0) chk(sb.pop_front());
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b1;
      bus.en = 1'b0; bus.mode = 2'b00; bus.d = 8'h00; bus.sin_r = 1'b0; bus.sin_l = 1'b0;
`ifdef UNIVERSAL_SHIFT_REG_ROTATE_EN
      bus.rot = 1'b0;
`endif
      // Reset asserted between edges must act without a clock
      #3 rst_n = 1'b0;
      #1 push(8'hA5, 4'd0, 1'b0, "reset_async");
      -> ev_rst;
      @(negedge clk) rst_n = 1'b1;

      // Load then shift right to drained and beyond
      cyc(1, 2'b11, 8'h81, 0, 0, 8'h81, 4'd0, 0, "load_81");
      cyc(1, 2'b01, 8'h00, 0, 0, 8'h40, 4'd1, 0, "sr1");
      cyc(1, 2'b01, 8'h00, 0, 0, 8'h20, 4'd2, 0, "sr2");
      cyc(1, 2'b01, 8'h00, 0, 0, 8'h10, 4'd3, 0, "sr3");
      cyc(1, 2'b01, 8'h00, 0, 0, 8'h08, 4'd4, 0, "sr4");
      cyc(1, 2'b01, 8'h00, 0, 0, 8'h04, 4'd5, 0, "sr5");
      cyc(1, 2'b01, 8'h00, 0, 0, 8'h02, 4'd6, 0, "sr6");
      cyc(1, 2'b01, 8'h00, 0, 0, 8'h01, 4'd7, 0, "sr7");
      cyc(1, 2'b01, 8'h00, 0, 0, 8'h00, 4'd8, 1, "sr8_drained");
      cyc(1, 2'b01, 8'h00, 0, 0, 8'h00, 4'd8, 1, "sr9_saturate");
      cyc(1, 2'b00, 8'hFF, 1, 1, 8'h00, 4'd8, 1, "hold_mode");

      // Shift left with enable gating; load also clears drained
      cyc(1, 2'b11, 8'h01, 0, 0, 8'h01, 4'd0, 0, "load_01");
      cyc(1, 2'b10, 8'h00, 0, 1, 8'h03, 4'd1, 0, "sl_en1");
      cyc(0, 2'b10, 8'h00, 0, 1, 8'h03, 4'd1, 0, "sl_en0_hold");
      cyc(1, 2'b10, 8'h00, 0, 1, 8'h07, 4'd2, 0, "sl_en1_again");
      cyc(0, 2'b11, 8'h99, 0, 0, 8'h07, 4'd2, 0, "load_gated");

      // Load wins the counter
      cyc(1, 2'b11, 8'hFF, 0, 0, 8'hFF, 4'd0, 0, "load_FF");
      cyc(1, 2'b10, 8'h00, 0, 0, 8'hFE, 4'd1, 0, "slF1");
      cyc(1, 2'b10, 8'h00, 0, 0, 8'hFC, 4'd2, 0, "slF2");
      cyc(1, 2'b10, 8'h00, 0, 0, 8'hF8, 4'd3, 0, "slF3");
      cyc(1, 2'b10, 8'h00, 0, 0, 8'hF0, 4'd4, 0, "slF4");
      cyc(1, 2'b10, 8'h00, 0, 0, 8'hE0, 4'd5, 0, "slF5");
      cyc(1, 2'b11, 8'h3C, 0, 0, 8'h3C, 4'd0, 0, "load_3C");

      // Mode changes every cycle
      cyc(1, 2'b11, 8'hAA, 0, 0, 8'hAA, 4'd0, 0, "load_AA");
      cyc(1, 2'b01, 8'h00, 1, 0, 8'hD5, 4'd1, 0, "mix_sr");
      cyc(1, 2'b10, 8'h00, 1, 0, 8'hAA, 4'd2, 0, "mix_sl");
      cyc(1, 2'b00, 8'h00, 1, 1, 8'hAA, 4'd2, 0, "mix_hold");

      // Reset mid-run
      cyc(1, 2'b11, 8'hF0, 0, 0, 8'hF0, 4'd0, 0, "load_F0");
      cyc(1, 2'b01, 8'h00, 0, 0, 8'h78, 4'd1, 0, "rr1");
      cyc(1, 2'b01, 8'h00, 0, 0, 8'h3C, 4'd2, 0, "rr2");
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 push(8'hA5, 4'd0, 1'b0, "reset_midrun");
      -> ev_rst;
      bus.en = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      cyc(1, 2'b01, 8'h00, 1, 0, 8'hD2, 4'd1, 0, "post_reset_sr");

`ifdef UNIVERSAL_SHIFT_REG_ROTATE_EN
      // Rotations
      cyc(1, 2'b11, 8'h81, 0, 0, 8'h81, 4'd0, 0, "rot_load1");
      @(negedge clk) bus.rot = 1'b1;
      cyc(1, 2'b01, 8'h00, 0, 0, 8'hC0, 4'd1, 0, "rot_r1");
      cyc(1, 2'b11, 8'h81, 0, 0, 8'h81, 4'd0, 0, "rot_load2");
      cyc(1, 2'b10, 8'h00, 0, 0, 8'h03, 4'd1, 0, "rot_l1");
      cyc(1, 2'b11, 8'h81, 0, 0, 8'h81, 4'd0, 0, "rot_load3");
      cyc(1, 2'b01, 8'h00, 0, 0, 8'hC0, 4'd1, 0, "rot8_1");
      cyc(1, 2'b01, 8'h00, 0, 0, 8'h60, 4'd2, 0, "rot8_2");
      cyc(1, 2'b01, 8'h00, 0, 0, 8'h30, 4'd3, 0, "rot8_3");
      cyc(1, 2'b01, 8'h00, 0, 0, 8'h18, 4'd4, 0, "rot8_4");
      cyc(1, 2'b01, 8'h00, 0, 0, 8'h0C, 4'd5, 0, "rot8_5");
      cyc(1, 2'b01, 8'h00, 0, 0, 8'h06, 4'd6, 0, "rot8_6");
      cyc(1, 2'b01, 8'h00, 0, 0, 8'h03, 4'd7, 0, "rot8_7");
      cyc(1, 2'b01, 8'h00, 0, 0, 8'h81, 4'd8, 1, "rot8_8");
      @(negedge clk) bus.rot = 1'b0;
`endif

      // Drain the scoreboard
      @(negedge clk) bus.en = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
